muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide responder in the execute stage, alongside the ALU.

---
 rtl/rv32m_pkg.sv | 21 ++
 rtl/muldiv_iter.sv | 30 +++
 rtl/muldiv_unit.sv | 116 +++++++++++
 tb/tb_muldiv_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 opcodes, FSM states and the default datapath width.
package rv32m_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIN
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Single combinational step of the shared shift-add / restoring-divide datapath.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              div_mode,
  output logic [2*XLEN-1:0] acc_next,
  output logic              borrow
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff   = rem_sh - {1'b0, operand};
    borrow = diff[XLEN];
    // Divide mode leaves the new quotient bit at 0; the caller inserts ~borrow.
    if (div_mode) begin
      if (borrow) acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else        acc_next = {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/busy/done handshake, one datapath step per cycle.
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_e            state_q, state_d;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   result_q;

  logic              a_signed, b_signed, sa, sb, neg_in;
  logic [XLEN-1:0]   abs_a, abs_b, fast_result;
  logic              b_zero, ovf, fast, accept, last;
  logic [2*XLEN-1:0] it_next, acc_step, prod_fix;
  logic              it_borrow;
  logic [XLEN-1:0]   mul_res, div_mag, div_res, calc_result;

  always_comb begin
    a_signed = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    b_signed = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    sa       = a_signed & a[XLEN-1];
    sb       = b_signed & b[XLEN-1];
    abs_a    = sa ? -a : a;
    abs_b    = sb ? -b : b;
    // Remainder takes the dividend sign; everything else takes the product/quotient sign.
    neg_in   = (op[2] & op[1]) ? sa : (sa ^ sb);
    b_zero   = (b == '0);
    ovf      = ((op == F3_DIV) || (op == F3_REM)) &&
               (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    fast     = op[2] & (b_zero | ovf);
    if (b_zero) fast_result = op[1] ? a : '1;
    else        fast_result = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept   = start & ~flush & (state_q != ST_CALC);
    last     = (cnt_q == LAST);
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .acc      (acc_q),
    .operand  (opnd_q),
    .div_mode (op_q[2]),
    .acc_next (it_next),
    .borrow   (it_borrow)
  );

  always_comb begin
    acc_step    = {it_next[2*XLEN-1:1], op_q[2] ? ~it_borrow : it_next[0]};
    prod_fix    = neg_q ? -acc_step : acc_step;
    mul_res     = (op_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    div_mag     = op_q[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    div_res     = neg_q ? -div_mag : div_mag;
    calc_result = op_q[2] ? div_res : mul_res;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (accept)                 state_d = fast ? ST_FIN : ST_CALC;
        else if (state_q == ST_FIN) state_d = ST_IDLE;
      end
      ST_CALC: if (last) state_d = ST_FIN;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op;
        neg_q  <= neg_in;
        opnd_q <= abs_b;
        acc_q  <= {{XLEN{1'b0}}, abs_a};
        cnt_q  <= '0;
        if (fast) result_q <= fast_result;
      end else if ((state_q == ST_CALC) && !flush) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CW'(1);
        if (last) result_q <= calc_result;
      end
    end
  end

  assign busy   = (state_q == ST_CALC);
  assign done   = (state_q == ST_FIN);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model compared every cycle, plus directed literal checks.
module tb_muldiv_unit;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx = signed'(x);
    longint      sy = signed'(y);
    longint      ux = x;
    longint      uy = y;
    logic [63:0] p;
    logic        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      F3_MUL:    begin p = ux * uy; return p[31:0];  end
      F3_MULH:   begin p = sx * sy; return p[63:32]; end
      F3_MULHSU: begin p = sx * uy; return p[63:32]; end
      F3_MULHU:  begin p = ux * uy; return p[63:32]; end
      F3_DIV:    return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(signed'(x) / signed'(y));
      F3_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      F3_REM:    return (y == 0) ? x : ovf ? 32'h0 : 32'(signed'(x) % signed'(y));
      default:   return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && ((y == 0) ||
           (((f == F3_DIV) || (f == F3_REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)));
  endfunction

  // Reference: an accepted op is "in flight" for 32 cycles, then reports for one cycle.
  int          m_rem;
  logic        m_done;
  logic [31:0] m_res, m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_pend <= '0;
    end else if (flush) begin
      m_rem  <= 0;
      m_done <= 1'b0;
    end else if ((m_rem == 0) && start) begin
      m_pend <= ref_result(op, a, b);
      if (is_fast(op, a, b)) begin
        m_rem  <= 0;
        m_done <= 1'b1;
        m_res  <= ref_result(op, a, b);
      end else begin
        m_rem  <= 32;
        m_done <= 1'b0;
      end
    end else if (m_rem > 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      if (m_rem == 1) m_res <= m_pend;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model busy",   {31'b0, busy}, {31'b0, m_rem > 0});
    check("model done",   {31'b0, done}, {31'b0, m_done});
    check("model result", result, m_res);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns in the done cycle (or after a bounded wait).
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int k = 0;
    op = f; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " latency"}, k, exp_lat);
    check(name, result, exp);
  endtask

  initial begin
    int k;
    int nd;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #1 reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("reset busy",   {31'b0, busy}, 32'd0);
    check("reset done",   {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);

    run_op(F3_MUL,    32'd7,         32'd6,         32'd42,        32, "mul 7*6");
    idle(1);
    check("done one cycle", {31'b0, done}, 32'd0);
    run_op(F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32, "mulh -1*-1");
    idle(2);
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu max");
    idle(2);
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32, "mulhsu -1*2");
    idle(2);
    run_op(F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32, "mul low -1*-1");
    idle(2);
    run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32, "div -7/2");
    idle(2);
    run_op(F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32, "rem -7%2");
    idle(2);
    run_op(F3_DIVU,   32'd100,       32'd7,         32'd14,        32, "divu 100/7");
    idle(2);
    run_op(F3_REMU,   32'd100,       32'd7,         32'd2,         32, "remu 100%7");
    idle(2);
    run_op(F3_DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 32, "div min/2");
    idle(2);
    run_op(F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 0,  "divu by 0");
    idle(2);
    run_op(F3_REMU,   32'd5,         32'd0,         32'd5,         0,  "remu by 0");
    idle(2);
    run_op(F3_DIV,    32'd9,         32'd0,         32'hFFFF_FFFF, 0,  "div by 0");
    idle(2);
    run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,  "div overflow");
    idle(2);
    run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0,  "rem overflow");
    idle(2);
    run_op(F3_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         32, "rem 7%-2");
    idle(2);

    // Flush at cycle 10 of a DIV: no done, result keeps 1.
    op = F3_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(9);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      idle(1);
    end
    check("flush no done", nd, 0);
    check("flush result kept", result, 32'd1);

    // Flush beats start in the same cycle.
    op = F3_MUL; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    idle(1);
    start = 1'b0; flush = 1'b0;
    check("flush beats start", {31'b0, busy}, 32'd0);
    idle(2);

    // Start while busy is ignored.
    op = F3_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    idle(1);
    start = 1'b0;
    k = 0;
    idle(5); k += 5;
    op = F3_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    idle(1); k += 1;
    start = 1'b0;
    while (!done && k < 40) begin
      idle(1);
      k++;
    end
    check("ignored start latency", k, 32);
    check("ignored start result", result, 32'd14);
    idle(2);

    // Reset mid-CALC clears everything immediately.
    op = F3_MUL; a = 32'd7; b = 32'd6; start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(10);
    reset = 1'b1;
    #1;
    check("midreset busy",   {31'b0, busy}, 32'd0);
    check("midreset done",   {31'b0, done}, 32'd0);
    check("midreset result", result, 32'd0);
    idle(1);
    reset = 1'b0;
    idle(1);
    run_op(F3_MUL, 32'd3, 32'd5, 32'd15, 32, "mul 3*5 after reset");

    // Back-to-back issues in the FIN cycle.
    run_op(F3_MUL,  32'd7,   32'd6, 32'd42,        32, "b2b mul");
    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14,        32, "b2b divu");
    run_op(F3_DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF, 0,  "b2b fast");
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
